// File: rtl/fix_msg_parse.sv
// FIX tag=value stream parser with per-field output and checksum verdict.
// Tag "10" fields are checked against the mod-256 sum of the preceding message.
module fix_msg_parse #(
  parameter int VALUE_BYTES = 8,
  parameter int TAG_BYTES   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               byte_i,
  input  logic                     byte_valid_i,
  output logic [31:0]              tag_o,
  output logic [2:0]               tag_len_o,
  output logic [8*VALUE_BYTES-1:0] val_o,
  output logic [3:0]               val_len_o,
  output logic                     field_valid_o,
  output logic                     msg_end_o,
  output logic                     chk_ok_o,
  output logic                     chk_err_o,
  output logic                     err_o
);

  localparam int VW = 8 * VALUE_BYTES;

  typedef enum logic [1:0] {
    S_TAG,
    S_VAL,
    S_CHK,
    S_DISC
  } state_t;

  state_t          r_state;
  logic [31:0]     r_tag;
  logic [2:0]      r_tag_cnt;
  logic [VW-1:0]   r_val;
  logic [3:0]      r_val_cnt;
  logic [7:0]      r_sum_run;
  logic [7:0]      r_sum_commit;
  logic [7:0]      r_chk_ref;
  logic [9:0]      r_chk_num;
  logic            r_bad;

  logic            w_soh;
  logic            w_eq;
  logic            w_digit_ok;
  logic            w_is10;
  logic            w_tag_full;
  logic            w_val_full;
  logic            w_chk_ok;
  logic [7:0]      w_sum_next;
  logic [13:0]     w_num_ext;
  logic [9:0]      w_num_sat;

  assign w_soh      = (byte_i == 8'h01);
  assign w_eq       = (byte_i == 8'h3D);
  assign w_digit_ok = (byte_i >= 8'h30) && (byte_i <= 8'h39);
  assign w_is10     = (r_tag_cnt == 3'd2) && (r_tag[15:0] == 16'h3031);
  assign w_tag_full = (r_tag_cnt == 3'(TAG_BYTES));
  assign w_val_full = (r_val_cnt == 4'(VALUE_BYTES));
  assign w_sum_next = r_sum_run + byte_i;
  assign w_num_ext  = 14'(r_chk_num) * 14'd10 + 14'(byte_i[3:0]);
  assign w_num_sat  = (w_num_ext > 14'd1023) ? 10'd1023 : w_num_ext[9:0];
  assign w_chk_ok   = (r_val_cnt == 4'd3) && !r_bad &&
                      (r_chk_num == {2'b00, r_chk_ref});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_TAG;
      r_tag         <= '0;
      r_tag_cnt     <= '0;
      r_val         <= '0;
      r_val_cnt     <= '0;
      r_sum_run     <= '0;
      r_sum_commit  <= '0;
      r_chk_ref     <= '0;
      r_chk_num     <= '0;
      r_bad         <= 1'b0;
      tag_o         <= '0;
      tag_len_o     <= '0;
      val_o         <= '0;
      val_len_o     <= '0;
      field_valid_o <= 1'b0;
      msg_end_o     <= 1'b0;
      chk_ok_o      <= 1'b0;
      chk_err_o     <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      field_valid_o <= 1'b0;
      msg_end_o     <= 1'b0;
      chk_ok_o      <= 1'b0;
      chk_err_o     <= 1'b0;
      err_o         <= 1'b0;
      if (byte_valid_i) begin
        if (r_state != S_CHK) begin
          r_sum_run <= w_sum_next;
          if (w_soh) r_sum_commit <= w_sum_next;
        end
        unique case (r_state)
          S_TAG: begin
            if (w_soh) begin
              err_o     <= 1'b1;
              r_tag     <= '0;
              r_tag_cnt <= '0;
            end else if (w_eq) begin
              if (r_tag_cnt == 3'd0) begin
                err_o   <= 1'b1;
                r_state <= S_DISC;
              end else if (w_is10) begin
                r_state   <= S_CHK;
                r_chk_ref <= r_sum_commit;
                r_chk_num <= '0;
                r_bad     <= 1'b0;
              end else begin
                r_state <= S_VAL;
              end
            end else if (w_tag_full) begin
              err_o   <= 1'b1;
              r_state <= S_DISC;
            end else begin
              for (int i = 0; i < TAG_BYTES; i++)
                if (r_tag_cnt == 3'(i)) r_tag[8*i +: 8] <= byte_i;
              r_tag_cnt <= r_tag_cnt + 3'd1;
            end
          end
          S_VAL, S_CHK: begin
            if (w_soh) begin
              tag_o         <= r_tag;
              tag_len_o     <= r_tag_cnt;
              val_o         <= r_val;
              val_len_o     <= r_val_cnt;
              field_valid_o <= 1'b1;
              r_tag         <= '0;
              r_tag_cnt     <= '0;
              r_val         <= '0;
              r_val_cnt     <= '0;
              r_state       <= S_TAG;
              if (r_state == S_CHK) begin
                msg_end_o    <= 1'b1;
                chk_ok_o     <= w_chk_ok;
                chk_err_o    <= !w_chk_ok;
                r_sum_run    <= '0;
                r_sum_commit <= '0;
                r_chk_num    <= '0;
                r_bad        <= 1'b0;
              end
            end else if (w_val_full) begin
              err_o   <= 1'b1;
              r_state <= S_DISC;
            end else begin
              for (int i = 0; i < VALUE_BYTES; i++)
                if (r_val_cnt == 4'(i)) r_val[8*i +: 8] <= byte_i;
              r_val_cnt <= r_val_cnt + 4'd1;
              if (r_state == S_CHK) begin
                if (w_digit_ok) r_chk_num <= w_num_sat;
                else            r_bad     <= 1'b1;
              end
            end
          end
          S_DISC: begin
            if (w_soh) begin
              r_tag     <= '0;
              r_tag_cnt <= '0;
              r_val     <= '0;
              r_val_cnt <= '0;
              r_state   <= S_TAG;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fix_msg_parse.sv
// Scoreboard bench for fix_msg_parse: queue-based reference model,
// directed FIX messages followed by randomized message streams.
module tb_fix_msg_parse;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic [31:0] tag_o;
  logic [2:0]  tag_len_o;
  logic [63:0] val_o;
  logic [3:0]  val_len_o;
  logic        field_valid_o;
  logic        msg_end_o;
  logic        chk_ok_o;
  logic        chk_err_o;
  logic        err_o;

  fix_msg_parse #(.VALUE_BYTES(8), .TAG_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .tag_o(tag_o), .tag_len_o(tag_len_o),
    .val_o(val_o), .val_len_o(val_len_o),
    .field_valid_o(field_valid_o), .msg_end_o(msg_end_o),
    .chk_ok_o(chk_ok_o), .chk_err_o(chk_err_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        fv;
    logic        me;
    logic        ok;
    logic        ce;
    logic        er;
    logic [31:0] tag;
    logic [2:0]  tl;
    logic [63:0] val;
    logic [3:0]  vl;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  gaps  = 0;

  // Reference model: field contents kept as byte queues, sums as integers
  int         m_st;
  logic [7:0] m_tag[$];
  logic [7:0] m_val[$];
  int         m_run;
  int         m_commit;
  int         m_ref;

  function automatic void model_reset();
    m_st = 0;
    m_tag.delete();
    m_val.delete();
    m_run = 0;
    m_commit = 0;
    m_ref = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b);
    ev_t     e;
    longint  n;
    bit      alld;
    e = '0;
    if (m_st != 2) begin
      m_run = (m_run + int'(b)) % 256;
      if (b == 8'h01) m_commit = m_run;
    end
    case (m_st)
      0: begin
        if (b == 8'h01) begin
          e.er = 1'b1;
          m_tag.delete();
        end else if (b == "=") begin
          if (m_tag.size() == 0) begin
            e.er = 1'b1;
            m_st = 3;
          end else if (m_tag.size() == 2 && m_tag[0] == "1" &&
                       m_tag[1] == "0") begin
            m_st = 2;
            m_ref = m_commit;
          end else begin
            m_st = 1;
          end
        end else if (m_tag.size() == 4) begin
          e.er = 1'b1;
          m_st = 3;
        end else begin
          m_tag.push_back(b);
        end
      end
      1, 2: begin
        if (b == 8'h01) begin
          e.fv = 1'b1;
          foreach (m_tag[i]) e.tag[8*i +: 8] = m_tag[i];
          foreach (m_val[i]) e.val[8*i +: 8] = m_val[i];
          e.tl = 3'(m_tag.size());
          e.vl = 4'(m_val.size());
          if (m_st == 2) begin
            n = 0;
            alld = 1;
            foreach (m_val[i]) begin
              if (m_val[i] >= "0" && m_val[i] <= "9")
                n = n * 10 + longint'(m_val[i] - 8'h30);
              else
                alld = 0;
            end
            if (n > 1023) n = 1023;
            e.me = 1'b1;
            e.ok = alld && m_val.size() == 3 && n == longint'(m_ref);
            e.ce = !e.ok;
            m_run = 0;
            m_commit = 0;
          end
          m_tag.delete();
          m_val.delete();
          m_st = 0;
        end else if (m_val.size() == 8) begin
          e.er = 1'b1;
          m_st = 3;
        end else begin
          m_val.push_back(b);
        end
      end
      default: begin
        if (b == 8'h01) begin
          m_tag.delete();
          m_val.delete();
          m_st = 0;
        end
      end
    endcase
    if (e.fv || e.er) exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t got;
    ev_t ex;
    if (field_valid_o === 1'b1 || err_o === 1'b1 || msg_end_o === 1'b1 ||
        chk_ok_o === 1'b1 || chk_err_o === 1'b1) begin
      got = {field_valid_o, msg_end_o, chk_ok_o, chk_err_o, err_o,
             tag_o, tag_len_o, val_o, val_len_o};
      if (!got.fv) begin
        got.tag = '0;
        got.tl  = '0;
        got.val = '0;
        got.vl  = '0;
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse got=%h required=none", got);
      end else begin
        ex = exp_q.pop_front();
        if (got !== ex) begin
          bad++;
          $display("FAIL event got fv%b me%b ok%b ce%b er%b tag=%h/%0d val=%h/%0d required fv%b me%b ok%b ce%b er%b tag=%h/%0d val=%h/%0d",
                   got.fv, got.me, got.ok, got.ce, got.er, got.tag, got.tl,
                   got.val, got.vl, ex.fv, ex.me, ex.ok, ex.ce, ex.er,
                   ex.tag, ex.tl, ex.val, ex.vl);
        end
      end
    end
  end

  task automatic send(logic [7:0] b);
    if (gaps) begin
      byte_valid_i = 1'b0;
      repeat ($urandom_range(1, 3)) begin
        @(posedge clk);
        #1;
      end
    end
    byte_i = b;
    byte_valid_i = 1'b1;
    model_byte(b);
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    byte_i = $urandom_range(0, 255);
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    total++;
    if ({tag_o, tag_len_o, val_o, val_len_o, field_valid_o, msg_end_o,
         chk_ok_o, chk_err_o, err_o} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got tag=%h val=%h pulses=%b required all zero",
               tag_o, val_o,
               {field_valid_o, msg_end_o, chk_ok_o, chk_err_o, err_o});
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_msg();
    int nf;
    int tl;
    int vl;
    int v;
    string s;
    nf = $urandom_range(1, 4);
    for (int f = 0; f < nf; f++) begin
      v = $urandom_range(0, 9);
      tl = (v == 0) ? 0 : (v == 1) ? 5 : $urandom_range(1, 4);
      for (int i = 0; i < tl; i++)
        send(8'((i == 0) ? $urandom_range(50, 57) : $urandom_range(48, 57)));
      if (v == 2) begin
        send(8'h01);
      end else begin
        send("=");
        vl = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 8);
        for (int i = 0; i < vl; i++) send(8'($urandom_range(32, 126)));
        send(8'h01);
      end
    end
    v = $urandom_range(0, 4);
    case (v)
      0, 1: s = $sformatf("%03d", m_commit);
      2:    s = $sformatf("%03d", (m_commit + 1) % 256);
      3:    s = $sformatf("%0d", m_commit % 100);
      default: s = "1x8";
    endcase
    send_str("10=");
    send_str(s);
    send(8'h01);
  endtask

  initial begin
    model_reset();
    do_reset();

    send_str("35=A");
    send(8'h01);

    send_str("8=F");
    send(8'h01);
    send_str("10=188");
    send(8'h01);

    send_str("8=F");
    send(8'h01);
    send_str("10=187");
    send(8'h01);

    send_str("8=F");
    send(8'h01);
    send_str("10=18");
    send(8'h01);

    send_str("12345=1");
    send(8'h01);
    send_str("9=5");
    send(8'h01);

    send_str("58=ABCDEFGHI");
    send(8'h01);
    send_str("7=Q");
    send(8'h01);

    idle(2);
    send_str("44=AB");
    idle(1);
    do_reset();
    send_str("1=X");
    send(8'h01);
    send_str("10=199");
    send(8'h01);

    gaps = 1;
    send_str("8=F");
    send(8'h01);
    send_str("10=188");
    send(8'h01);

    for (int m = 0; m < 40; m++) begin
      gaps = ($urandom_range(0, 1) == 1);
      rand_msg();
    end
    gaps = 0;

    idle(5);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_events got=%0d pending required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fix_msg_parse.md
FIX_MSG_PARSE -- requirements
Module: fix_msg_parse

Interface
REQ-001 Parameter VALUE_BYTES, 8, maximum value length in bytes; val_o width = 8*VALUE_BYTES.
REQ-002 Parameter TAG_BYTES, 4, maximum tag length in bytes; tag_o width = 32.
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 byte_i  input  8  incoming FIX stream byte, ASCII.
REQ-006 byte_valid_i  input  1  byte_i valid this cycle; the block is always ready and has no backpressure.
REQ-007 tag_o  output  32  tag bytes of the last field; first received byte in [7:0], unused bytes zero.
REQ-008 tag_len_o  output  3  tag byte count, 1..4.
REQ-009 val_o  output  8*VALUE_BYTES  value bytes; first byte in [7:0], unused bytes zero.
REQ-010 val_len_o  output  4  value byte count, 0..VALUE_BYTES.
REQ-011 field_valid_o  output  1  one-cycle pulse; tag/val outputs valid.
REQ-012 msg_end_o  output  1  one-cycle pulse; checksum field (tag "10") completed.
REQ-013 chk_ok_o, chk_err_o  output  1 each  one-cycle checksum verdict pulses, coincident with msg_end_o.
REQ-014 err_o  output  1  one-cycle pulse on a framing error.

Function
REQ-015 Delimiters: '=' (0x3D) ends the tag; SOH (0x01) ends the value. Only cycles with byte_valid_i=1 advance any state or counter.
REQ-016 States: TAG (collect tag bytes), VAL (collect value bytes), CHK (collect checksum digits), DISCARD (drop bytes until SOH).
REQ-017 TAG, non-delimiter byte: store the byte at index tag_cnt and increment tag_cnt; a 5th byte causes err_o, then DISCARD.
REQ-018 TAG, '=' with tag_cnt=0: err_o, then DISCARD.
REQ-019 TAG, '=' with the stored tag equal to 0x3031 ("10") and tag_cnt=2: go to CHK and freeze chk_ref = sum_commit; otherwise go to VAL.
REQ-020 TAG, SOH: err_o, clear tag_cnt, remain in TAG.
REQ-021 VAL, non-SOH byte: store the byte at index val_cnt and increment val_cnt; byte VALUE_BYTES+1 causes err_o, then DISCARD.
REQ-022 VAL, SOH: on the next cycle, register tag_o, tag_len_o, val_o, val_len_o and pulse field_valid_o (1-cycle latency); clear counters; go to TAG.
REQ-023 CHK, each byte before SOH: also store it into val_o as in VAL.
REQ-024 CHK digit accumulation: chk_num = chk_num*10 + (byte-0x30), 10 bits, saturating at 1023; set bad_digit on any byte outside 0x30-0x39.
REQ-025 CHK, SOH: on the next cycle, pulse field_valid_o, msg_end_o and exactly one of chk_ok_o/chk_err_o.
REQ-026 chk_ok_o requires digit count = 3, bad_digit = 0 and chk_num = {2'b00, chk_ref}; any other case gives chk_err_o.
REQ-027 After CHK SOH: clear sum_run, sum_commit, chk_num and bad_digit; go to TAG.
REQ-028 Checksum arithmetic: sum_run is an 8-bit modulo-256 sum of every valid byte received outside CHK, including delimiters and bytes in DISCARD.
REQ-029 On every SOH outside CHK: sum_commit <= sum_run + 0x01 (the SOH included).
REQ-030 Checksum exclusion: bytes of the tag-10 field ("10=", digits, SOH) are excluded from the sum.
REQ-031 DISCARD, SOH: no field_valid_o; clear counters; go to TAG.
REQ-032 Pulse outputs are low in every cycle not named above.
REQ-033 tag_o, tag_len_o, val_o and val_len_o hold their values until the next field_valid_o.

Reset
REQ-034 rst=1 at a clock edge: state TAG; all counters, sums and flags zero.
REQ-035 rst=1 at a clock edge: all outputs zero, overriding any in-progress field or pending pulse.
REQ-036 After rst falls, the first valid byte is treated as the first tag byte.

Verification
REQ-037 "35=A",SOH -> one cycle after SOH: field_valid_o=1, tag_o=0x00003533, tag_len_o=2, val_o=0x41, val_len_o=1.
REQ-038 "8=F",SOH,"10=188",SOH -> two field_valid_o pulses; second with msg_end_o=1 and chk_ok_o=1 (0x38+0x3D+0x46+0x01=188).
REQ-039 Same message with "10=187" or "10=18" -> chk_err_o=1, chk_ok_o=0.
REQ-040 "12345=1",SOH,"9=5",SOH -> err_o on byte '5'; no field for the first; second field tag_o=0x39, val_o=0x35.
REQ-041 9-byte value after "58=" -> err_o on the 9th byte, no field_valid_o; the next field parses normally.
REQ-042 rst pulsed mid-value, then "1=X",SOH -> outputs zero during reset; field tag_o=0x31, val_o=0x58; checksum sum restarts at 0.
REQ-043 byte_valid_i gaps inserted between every byte of REQ-038 -> identical results.
